// File: rtl/joint_servo_driver.sv
// rtl/joint_servo_driver.sv - two-joint hobby-servo PWM driver with per-frame slew limiting
// Angles arrive as Q16.16 degrees; each frame moves the joints at most SLEW_DEG toward the target.
module joint_servo_driver #(
  parameter int unsigned CLKS_PER_US  = 50,
  parameter int unsigned PERIOD_US    = 20000,
  parameter int unsigned MIN_PULSE_US = 1000,
  parameter int unsigned MAX_PULSE_US = 2000,
  parameter int unsigned SLEW_DEG     = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [31:0] i_q_theta_1,
  input  logic [31:0] i_q_theta_2,
  output logic        o_pwm_1,
  output logic        o_pwm_2,
  output logic [7:0]  o_pos_deg_1,
  output logic [7:0]  o_pos_deg_2,
  output logic        o_settled,
  output logic        o_frame_tick
);

  localparam logic [31:0] PERIOD_TICKS = 32'(PERIOD_US * CLKS_PER_US);
  localparam logic [31:0] MIN_TICKS    = 32'(MIN_PULSE_US * CLKS_PER_US);
  localparam logic [31:0] STEP_TICKS   = 32'(((MAX_PULSE_US - MIN_PULSE_US) * CLKS_PER_US) / 180);
  localparam logic [7:0]  SLEW         = 8'(SLEW_DEG);
  localparam logic [7:0]  HOME_DEG     = 8'd90;
  localparam logic [31:0] HOME_WIDTH   = MIN_TICKS + 32'd90 * STEP_TICKS;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_frame_upd;
  logic        w_accept;
  logic        r_cmd_seen;
  logic [31:0] r_counter;
  logic [7:0]  r_tgt_1, r_tgt_2;
  logic [7:0]  r_cur_1, r_cur_2;
  logic [31:0] r_width_1, r_width_2;
  logic [7:0]  w_new_cur_1, w_new_cur_2;

  // Floor to integer degrees (arithmetic shift), then clamp to the servo range.
  function automatic logic [7:0] to_deg(input logic [31:0] q);
    logic signed [31:0] d;
    d = $signed(q) >>> 16;
    if (d < 0)
      return 8'd0;
    else if (d > 180)
      return 8'd180;
    else
      return d[7:0];
  endfunction

  function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt);
    if (tgt > cur)
      return ((tgt - cur) > SLEW) ? cur + SLEW : tgt;
    else
      return ((cur - tgt) > SLEW) ? cur - SLEW : tgt;
  endfunction

  assign o_cmd_ready = ~i_reset;
  assign w_accept    = i_cmd_valid & ~i_reset;

  assign w_new_cur_1 = slew_step(r_cur_1, r_tgt_1);
  assign w_new_cur_2 = slew_step(r_cur_2, r_tgt_2);

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_frame_upd  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable && (r_cmd_seen || w_accept)) begin
          w_next_state = S_RUN;
          w_frame_upd  = 1'b1;
        end
      end
      S_RUN: begin
        if (!i_enable)
          w_next_state = S_IDLE;
        else if (r_counter == PERIOD_TICKS - 32'd1)
          w_frame_upd = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Targets use the pre-edge value on a frame update, so a command on that edge lands next frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmd_seen <= 1'b0;
      r_counter  <= 32'd0;
      r_tgt_1    <= HOME_DEG;
      r_tgt_2    <= HOME_DEG;
      r_cur_1    <= HOME_DEG;
      r_cur_2    <= HOME_DEG;
      r_width_1  <= HOME_WIDTH;
      r_width_2  <= HOME_WIDTH;
    end else begin
      if (w_accept) begin
        r_tgt_1    <= to_deg(i_q_theta_1);
        r_tgt_2    <= to_deg(i_q_theta_2);
        r_cmd_seen <= 1'b1;
      end
      if (w_frame_upd) begin
        r_cur_1   <= w_new_cur_1;
        r_cur_2   <= w_new_cur_2;
        r_width_1 <= MIN_TICKS + {24'd0, w_new_cur_1} * STEP_TICKS;
        r_width_2 <= MIN_TICKS + {24'd0, w_new_cur_2} * STEP_TICKS;
      end
      if (w_next_state == S_IDLE || r_state == S_IDLE || r_counter == PERIOD_TICKS - 32'd1)
        r_counter <= 32'd0;
      else
        r_counter <= r_counter + 32'd1;
    end
  end

  assign o_pwm_1      = (r_state == S_RUN) && (r_counter < r_width_1);
  assign o_pwm_2      = (r_state == S_RUN) && (r_counter < r_width_2);
  assign o_frame_tick = (r_state == S_RUN) && (r_counter == 32'd0);
  assign o_settled    = (r_cur_1 == r_tgt_1) && (r_cur_2 == r_tgt_2);
  assign o_pos_deg_1  = r_cur_1;
  assign o_pos_deg_2  = r_cur_2;

endmodule

// File: tb/tb_joint_servo_driver.sv
// tb/tb_joint_servo_driver.sv - directed bench for joint_servo_driver
// Inputs change and outputs are sampled on the falling edge.
module tb_joint_servo_driver;

  localparam int PERIOD = 3000;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] theta_1;
  logic [31:0] theta_2;
  logic        pwm_1, pwm_2;
  logic [7:0]  pos_1, pos_2;
  logic        settled;
  logic        frame_tick;

  int total;
  int bad;
  int w1, w2;

  joint_servo_driver #(
    .CLKS_PER_US (1),
    .PERIOD_US   (3000),
    .MIN_PULSE_US(1000),
    .MAX_PULSE_US(2000),
    .SLEW_DEG    (2)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_enable    (enable),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_q_theta_1 (theta_1),
    .i_q_theta_2 (theta_2),
    .o_pwm_1     (pwm_1),
    .o_pwm_2     (pwm_2),
    .o_pos_deg_1 (pos_1),
    .o_pos_deg_2 (pos_2),
    .o_settled   (settled),
    .o_frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts high cycles of both outputs across one frame starting at the next frame tick.
  task automatic measure(output int m1, output int m2);
    int guard;
    guard = 0;
    m1 = 0;
    m2 = 0;
    while (!frame_tick && guard < 4000) begin
      step(1);
      guard++;
    end
    chk("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) step(1);
      m1 += int'(pwm_1);
      m2 += int'(pwm_2);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    cmd_valid = 1'b0;
    theta_1   = 32'd0;
    theta_2   = 32'd0;

    // Reset state, then enable without any command.
    step(2);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_pwm_1", {31'd0, pwm_1}, 32'd0);
    chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    reset  = 1'b0;
    enable = 1'b1;
    step(5);
    chk("nocmd_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("nocmd_pwm_1", {31'd0, pwm_1}, 32'd0);
    chk("nocmd_pwm_2", {31'd0, pwm_2}, 32'd0);
    chk("nocmd_tick", {31'd0, frame_tick}, 32'd0);
    chk("nocmd_pos_1", {24'd0, pos_1}, 32'd90);
    chk("nocmd_pos_2", {24'd0, pos_2}, 32'd90);
    chk("nocmd_settled", {31'd0, settled}, 32'd1);

    // 92.5 / 89 degrees, then enable.
    enable = 1'b0;
    step(1);
    cmd_valid = 1'b1;
    theta_1   = 32'h005C_8000;
    theta_2   = 32'h0059_0000;
    step(1);
    cmd_valid = 1'b0;
    chk("cmd1_unsettled", {31'd0, settled}, 32'd0);
    enable = 1'b1;
    step(1);
    chk("cmd1_tick", {31'd0, frame_tick}, 32'd1);
    chk("cmd1_pos_1", {24'd0, pos_1}, 32'd92);
    chk("cmd1_pos_2", {24'd0, pos_2}, 32'd89);
    chk("cmd1_settled", {31'd0, settled}, 32'd1);
    measure(w1, w2);
    chk("cmd1_width_1", 32'(w1), 32'd1460);
    chk("cmd1_width_2", 32'(w2), 32'd1445);

    // Command lands exactly on the wrap edge (counter is at PERIOD-1 now).
    cmd_valid = 1'b1;
    theta_1   = 32'h0064_0000;
    theta_2   = 32'h0059_0000;
    step(1);
    cmd_valid = 1'b0;
    chk("wrap_tick", {31'd0, frame_tick}, 32'd1);
    chk("wrap_pos_1", {24'd0, pos_1}, 32'd92);
    measure(w1, w2);
    chk("wrap_old_width_1", 32'(w1), 32'd1460);
    chk("wrap_old_width_2", 32'(w2), 32'd1445);
    measure(w1, w2);
    chk("wrap_new_width_1", 32'(w1), 32'd1470);
    chk("wrap_new_pos_1", {24'd0, pos_1}, 32'd94);

    // Disable mid-pulse at counter 500, then re-enable.
    step(501);
    chk("dis_pre_pwm_1", {31'd0, pwm_1}, 32'd1);
    chk("dis_pre_pos_1", {24'd0, pos_1}, 32'd96);
    enable = 1'b0;
    step(1);
    chk("dis_pwm_1", {31'd0, pwm_1}, 32'd0);
    chk("dis_pwm_2", {31'd0, pwm_2}, 32'd0);
    step(3);
    chk("dis_hold_pwm_1", {31'd0, pwm_1}, 32'd0);
    chk("dis_hold_pos_1", {24'd0, pos_1}, 32'd96);
    enable = 1'b1;
    step(1);
    chk("reen_tick", {31'd0, frame_tick}, 32'd1);
    chk("reen_pos_1", {24'd0, pos_1}, 32'd98);
    chk("reen_pwm_1", {31'd0, pwm_1}, 32'd1);
    measure(w1, w2);
    chk("reen_width_1", 32'(w1), 32'd1490);
    chk("reen_width_2", 32'(w2), 32'd1445);

    // Reset pulse at counter 200 while PWM is high.
    step(201);
    chk("rstmid_pre_pwm_1", {31'd0, pwm_1}, 32'd1);
    reset = 1'b1;
    step(1);
    chk("rstmid_pwm_1", {31'd0, pwm_1}, 32'd0);
    chk("rstmid_pwm_2", {31'd0, pwm_2}, 32'd0);
    chk("rstmid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rstmid_pos_1", {24'd0, pos_1}, 32'd90);
    chk("rstmid_pos_2", {24'd0, pos_2}, 32'd90);
    reset = 1'b0;
    step(10);
    chk("rstmid_nocmd_pwm_1", {31'd0, pwm_1}, 32'd0);
    chk("rstmid_nocmd_tick", {31'd0, frame_tick}, 32'd0);
    chk("rstmid_settled", {31'd0, settled}, 32'd1);

    // Out-of-range command clamps to 0 / 180 and slews 2 degrees per frame.
    enable    = 1'b0;
    cmd_valid = 1'b1;
    theta_1   = 32'hFFF6_0000;
    theta_2   = 32'h00C8_0000;
    step(1);
    cmd_valid = 1'b0;
    enable    = 1'b1;
    step(1);
    chk("clamp_pos_1_f1", {24'd0, pos_1}, 32'd88);
    chk("clamp_pos_2_f1", {24'd0, pos_2}, 32'd92);
    measure(w1, w2);
    chk("clamp_width_1_f1", 32'(w1), 32'd1440);
    chk("clamp_width_2_f1", 32'(w2), 32'd1460);
    measure(w1, w2);
    chk("clamp_pos_1_f2", {24'd0, pos_1}, 32'd86);
    chk("clamp_pos_2_f2", {24'd0, pos_2}, 32'd94);
    chk("clamp_width_1_f2", 32'(w1), 32'd1430);
    // Each disable/enable pair forces a frame update, so the slew runs without full frames.
    for (int k = 3; k <= 45; k++) begin
      enable = 1'b0;
      step(1);
      enable = 1'b1;
      step(1);
      chk("clamp_pos_1_fk", {24'd0, pos_1}, 32'(90 - 2 * k));
      chk("clamp_pos_2_fk", {24'd0, pos_2}, 32'(90 + 2 * k));
    end
    chk("clamp_settled", {31'd0, settled}, 32'd1);
    measure(w1, w2);
    chk("clamp_final_width_1", 32'(w1), 32'd1000);
    chk("clamp_final_width_2", 32'(w2), 32'd1900);
    measure(w1, w2);
    chk("clamp_hold_pos_1", {24'd0, pos_1}, 32'd0);
    chk("clamp_hold_pos_2", {24'd0, pos_2}, 32'd180);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
